// File: rtl/serial_adder_seq.sv
// Multi-cycle ripple adder/subtractor that processes CHUNK bits per clock.
// An operation takes WIDTH/CHUNK cycles and ends with a one-cycle done pulse.
module serial_adder_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("serial_adder_seq: WIDTH must be in 2..64");
        end
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("serial_adder_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] cs;
    logic             cc;
    logic             cm;

    // cm ends up as the carry into the top stage of the chunk,
    // which on the last chunk is the carry into the MSB.
    always_comb begin
        ca = a_r[cnt*CHUNK +: CHUNK];
        cb = b_r[cnt*CHUNK +: CHUNK];
        cs = '0;
        cc = c;
        cm = c;
        for (int i = 0; i < CHUNK; i++) begin
            cm    = cc;
            cs[i] = ca[i] ^ cb[i] ^ cc;
            cc    = (ca[i] & cb[i]) | (cc & (ca[i] ^ cb[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            Sum      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r      <= A;
                        b_r      <= mode ? ~B : B;
                        c        <= mode ? 1'b1 : cin;
                        cnt      <= '0;
                        Sum      <= '0;
                        Carry    <= 1'b0;
                        Overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    Sum[cnt*CHUNK +: CHUNK] <= cs;
                    c <= cc;
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        Carry    <= cc;
                        Overflow <= cm ^ cc;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_adder_seq.md
SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Parameter CHUNK, default 1, bits processed per clock; WIDTH % CHUNK != 0 SHALL cause an elaboration error.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port start  input  1  request a new operation; sampled only when the block is idle or in done (REQ-012).
REQ-006 Port mode  input  1  0 = add (A + B + cin), 1 = subtract (A - B).
REQ-007 Port A  input  WIDTH  first operand, captured on start acceptance.
REQ-008 Port B  input  WIDTH  second operand, captured on start acceptance.
REQ-009 Port cin  input  1  carry-in for add, captured on start acceptance; ignored when mode=1.
REQ-010 Port Sum  output  WIDTH  result; Carry  output  1  carry-out (mode=1: 1 = no borrow); Overflow  output  1  two's-complement overflow; busy  output  1  operation in progress; done  output  1  one-cycle result-valid pulse.

Function
REQ-011 FSM states: IDLE, RUN, DONE; N = WIDTH/CHUNK.
REQ-012 IDLE or DONE with start=1 at edge k: latch A, B'=(mode ? ~B : B), carry register c=(mode ? 1 : cin), clear chunk counter and Sum, go to RUN.
REQ-013 IDLE with start=0: stay IDLE; DONE with start=0: go to IDLE.
REQ-014 RUN: at edge k+j (j=1..N), process chunk j-1 (bits [j*CHUNK-1 : (j-1)*CHUNK]) as CHUNK chained full-adder stages (per stage Sum=a^b^c, carry=a&b | c&(a^b)); write result bits into Sum, update c.
REQ-015 At edge k+N: go to DONE; Carry = final carry; Overflow = carry into MSB XOR carry out of MSB.
REQ-016 Latency: done SHALL be high exactly the cycle after edge k+N, for one cycle only (unless re-armed per REQ-012, in which case done still deasserts).
REQ-017 busy=1 exactly while in RUN (N cycles); busy=0 in IDLE and DONE.
REQ-018 start while in RUN SHALL be ignored; operands/mode changes during RUN SHALL not affect the result.
REQ-019 Sum, Carry, Overflow SHALL hold their last result from DONE until the next accepted start; Sum bits not yet processed in RUN read 0.
REQ-020 Arithmetic modulo 2^WIDTH; no saturation.
REQ-021 Back-to-back: start=1 in the done cycle SHALL begin a new operation with no idle gap.

Reset
REQ-022 rst=1 at any edge SHALL force IDLE, clear counter and carry register, and set Sum=0, Carry=0, Overflow=0, busy=0, done=0; rst SHALL take priority over start.
REQ-023 rst during RUN SHALL abandon the operation with no done pulse; first start after rst is accepted normally.

Verification
REQ-024 WIDTH=8, CHUNK=1: A=0xFF, B=0x01, cin=0, mode=0 -> after 8 busy cycles done=1, Sum=0x00, Carry=1, Overflow=0.
REQ-025 WIDTH=8, CHUNK=1: A=0x7F, B=0x01, mode=0 -> Sum=0x80, Carry=0, Overflow=1; A=0x80, B=0x01, mode=1 -> Sum=0x7F, Carry=1, Overflow=1.
REQ-026 WIDTH=8, CHUNK=4: A=0x05, B=0x07, mode=1 -> busy exactly 2 cycles, Sum=0xFE, Carry=0 (borrow), Overflow=0.
REQ-027 WIDTH=8, CHUNK=1: start at cycle 0, pulse start and change A/B at cycle 3 -> result matches original operands; done once at cycle 8 relative to the accepting edge.
REQ-028 rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, Sum=0; no done pulse follows; new start completes correctly.
REQ-029 start held high continuously -> done pulses every N+1 cycles, each result correct for the operands sampled at its accepting edge; random compare vs. A+B+cin / A-B for WIDTH in {2,8,32}, CHUNK in {1,2,WIDTH}.
